// File: rtl/unified_mem_be.sv
// Unified instruction/data memory with RV32 byte-enable stores, extended loads and
// a post-reset clear sequencer. Optional misalignment trap: MEM_MISALIGN_CHECK_EN.
module unified_mem_be #(
  parameter int unsigned DEPTH_LOG2     = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iAddr,
  output logic [31:0] instOut,
  input  logic [31:0] dAddr,
  input  logic [31:0] dataIn,
  input  logic        wEn,
  input  logic        rEn,
  input  logic [2:0]  funct3,
  output logic [31:0] memOut,
  output logic        ready,
  output logic        misalign
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic {CLEAR, RUN} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] clr_ptr_q, clr_ptr_d;
  logic [31:0]           ram_q [0:DEPTH-1];

  logic [DEPTH_LOG2-1:0] d_idx, i_idx;
  logic                  run;
  logic                  mis;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic [31:0]           dword;
  logic [7:0]            dbyte;
  logic [15:0]           dhalf;
  logic                  unused_ok;

  assign d_idx = dAddr[DEPTH_LOG2+1:2];
  assign i_idx = iAddr[DEPTH_LOG2+1:2];

  // Upper address bits alias by design; fetch ignores the byte offset.
  assign unused_ok = ^{iAddr[1:0], iAddr[31:DEPTH_LOG2+2], dAddr[31:DEPTH_LOG2+2], rEn};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == CLEAR) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == '1) state_d = RUN;
    end
  end

  always_comb begin
    run   = (state_q == RUN);
    ready = run;
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    mis = 1'b0;
    if (run && (wEn || rEn)) begin
      if ((funct3 == 3'b001 || funct3 == 3'b101) && dAddr[0])  mis = 1'b1;
      if (funct3 == 3'b010 && dAddr[1:0] != 2'b00)             mis = 1'b1;
    end
  end
`else
  assign mis = 1'b0;
`endif

  assign misalign = mis;

  always_comb begin
    be    = '0;
    wdata = '0;
    case (funct3)
      3'b000: begin
        be    = 4'b0001 << dAddr[1:0];
        wdata = {4{dataIn[7:0]}};
      end
      3'b001: begin
        be    = dAddr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{dataIn[15:0]}};
      end
      3'b010: begin
        be    = '1;
        wdata = dataIn;
      end
      default: ;
    endcase
    if (!run || !wEn || mis) be = '0;
  end

  // Clear sequencer shares the single write port and takes priority over stores.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      ram_q[clr_ptr_q] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) ram_q[d_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    dword  = ram_q[d_idx];
    dbyte  = dword[8*dAddr[1:0] +: 8];
    dhalf  = dAddr[1] ? dword[31:16] : dword[15:0];
    memOut = '0;
    case (funct3)
      3'b000:  memOut = {{24{dbyte[7]}}, dbyte};
      3'b100:  memOut = {24'h0, dbyte};
      3'b001:  memOut = {{16{dhalf[15]}}, dhalf};
      3'b101:  memOut = {16'h0, dhalf};
      3'b010:  memOut = dword;
      default: memOut = '0;
    endcase
    if (!run || mis) memOut = '0;
  end

  assign instOut = run ? ram_q[i_idx] : '0;

endmodule

// File: tb/tb_unified_mem_be.sv
// Directed bench for unified_mem_be at DEPTH=16; expectations are hand-computed.
module tb_unified_mem_be;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iAddr, dAddr, dataIn;
  logic        wEn, rEn;
  logic [2:0]  funct3;
  logic [31:0] instOut, memOut;
  logic        ready, misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unified_mem_be #(.DEPTH_LOG2(4), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .iAddr(iAddr), .instOut(instOut), .dAddr(dAddr),
    .dataIn(dataIn), .wEn(wEn), .rEn(rEn), .funct3(funct3), .memOut(memOut),
    .ready(ready), .misalign(misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    funct3 = f; dAddr = a; dataIn = d; wEn = 1'b1;
    @(posedge clk); #1;
    wEn = 1'b0;
  endtask

  task automatic load(input string tag, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] exp);
    @(negedge clk);
    funct3 = f; dAddr = a; rEn = 1'b1;
    #1 chk(tag, memOut, exp);
    rEn = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; iAddr = '0; dAddr = '0; dataIn = '0; wEn = 1'b0; rEn = 1'b0; funct3 = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {31'h0, ready}, 32'h0);
    chk("reset_inst", instOut, 32'h0);
    chk("reset_mem", memOut, 32'h0);

    @(negedge clk) rst = 1'b1;
    repeat (15) @(posedge clk);
    #1 chk("clear_ready_15", {31'h0, ready}, 32'h0);
    @(posedge clk);
    #1 chk("clear_ready_16", {31'h0, ready}, 32'h1);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      iAddr = 32'(i * 4); dAddr = 32'(i * 4); funct3 = 3'b010;
      #1;
      chk("zero_inst", instOut, 32'h0);
      chk("zero_lw", memOut, 32'h0);
    end

    store(3'b010, 32'h0, 32'hDEAD_BEEF);
    store(3'b010, 32'h3C, 32'h0BAD_F00D);
    load("pre_lw0", 3'b010, 32'h0, 32'hDEAD_BEEF);
    load("pre_lw15", 3'b010, 32'h3C, 32'h0BAD_F00D);

    // Reset mid-clear after seven clear cycles.
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    iAddr = 32'h3C;
    #1 chk("clear_inst_forced", instOut, 32'h0);
    repeat (7) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("midclr_ready", {31'h0, ready}, 32'h0);
    @(negedge clk) rst = 1'b1;
    repeat (15) @(posedge clk);
    #1 chk("restart_ready_15", {31'h0, ready}, 32'h0);
    @(posedge clk);
    #1 chk("restart_ready_16", {31'h0, ready}, 32'h1);
    load("restart_lw0", 3'b010, 32'h0, 32'h0);
    load("restart_lw15", 3'b010, 32'h3C, 32'h0);

    store(3'b010, 32'h4, 32'h8000_00F1);
    load("lb4", 3'b000, 32'h4, 32'hFFFF_FFF1);
    load("lbu4", 3'b100, 32'h4, 32'h0000_00F1);
    load("lh6", 3'b001, 32'h6, 32'hFFFF_8000);
    load("lhu6", 3'b101, 32'h6, 32'h0000_8000);
    load("lb7", 3'b000, 32'h7, 32'hFFFF_FF80);
    @(negedge clk) iAddr = 32'h4;
    #1 chk("fetch4", instOut, 32'h8000_00F1);

    store(3'b010, 32'h8, 32'h1122_3344);
    store(3'b000, 32'hA, 32'h0000_00AA);
    load("sb_merge", 3'b010, 32'h8, 32'h11AA_3344);

    @(negedge clk);
    iAddr = 32'h8; funct3 = 3'b001; dAddr = 32'h8; dataIn = 32'h0000_BEEF; wEn = 1'b1;
    #1 chk("rdw_old", instOut, 32'h11AA_3344);
    @(posedge clk);
    #1 chk("rdw_new", instOut, 32'h11AA_BEEF);
    wEn = 1'b0;

    store(3'b011, 32'h8, 32'hFFFF_FFFF);
    load("bad_store_code", 3'b010, 32'h8, 32'h11AA_BEEF);
    load("bad_load_code", 3'b011, 32'h8, 32'h0);

    store(3'b010, 32'h40, 32'hCAFE_0000);
    load("wrap", 3'b010, 32'h0, 32'hCAFE_0000);

    @(negedge clk);
    funct3 = 3'b010; dAddr = 32'h2; dataIn = 32'h1234_5678; wEn = 1'b1;
`ifdef MEM_MISALIGN_CHECK_EN
    #1 chk("sw2_misalign", {31'h0, misalign}, 32'h1);
    @(posedge clk); #1 wEn = 1'b0;
    load("sw2_suppressed", 3'b010, 32'h0, 32'hCAFE_0000);
    @(negedge clk);
    funct3 = 3'b001; dAddr = 32'h5; rEn = 1'b1;
    #1;
    chk("lh5_data", memOut, 32'h0);
    chk("lh5_misalign", {31'h0, misalign}, 32'h1);
    rEn = 1'b0;
`else
    #1 chk("sw2_misalign", {31'h0, misalign}, 32'h0);
    @(posedge clk); #1 wEn = 1'b0;
    load("sw2_truncated", 3'b010, 32'h0, 32'h1234_5678);
    @(negedge clk);
    funct3 = 3'b001; dAddr = 32'h5; rEn = 1'b1;
    #1;
    chk("lh5_data", memOut, 32'h0000_00F1);
    chk("lh5_misalign", {31'h0, misalign}, 32'h0);
    rEn = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
